// File: rtl/bcd_overlay_render.sv
// rtl/bcd_overlay_render.sv - BCD digit overlay renderer with frame-latched shadows and blink/alarm colouring
// Three pix_en-qualified stages: field hit/char lookup, font ROM fetch, colour select.
module bcd_overlay_render #(
  parameter int         N_FIELDS     = 3,
  parameter int         DIGITS       = 6,
  parameter int         SCALE_LOG2   = 1,
  parameter int         X0           = 192,
  parameter int         Y0           = 96,
  parameter int         Y_PITCH      = 160,
  parameter logic [7:0] FG_COLOR     = 8'h07,
  parameter logic [7:0] ALARM_COLOR  = 8'h1A,
  parameter int         BLINK_FRAMES = 30
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         pix_en_i,
  input  logic [9:0]                   pixel_x_i,
  input  logic [9:0]                   pixel_y_i,
  input  logic                         video_on_i,
  input  logic                         frame_start_i,
  input  logic [N_FIELDS*DIGITS*4-1:0] field_bcd_i,
  input  logic                         edit_i,
  input  logic [3:0]                   cursor_field_i,
  input  logic [3:0]                   cursor_digit_i,
  input  logic                         irq_i,
  output logic [10:0]                  rom_addr_o,
  input  logic [7:0]                   rom_data_i,
  output logic [7:0]                   rgb_o
);

  localparam int BCD_W   = N_FIELDS * DIGITS * 4;
  localparam int GLYPH_W = 8 << SCALE_LOG2;
  localparam int GLYPH_H = 16 << SCALE_LOG2;
  localparam int FIELD_W = DIGITS * GLYPH_W;

  logic [BCD_W-1:0] r_bcd;
  logic             r_edit;
  logic [3:0]       r_cur_f;
  logic [3:0]       r_cur_d;
  logic             r_irq;
  logic [7:0]       r_frame_cnt;
  logic             r_blink;

  logic             r1_hit;
  logic [6:0]       r1_code;
  logic [3:0]       r1_row;
  logic [2:0]       r1_bit;
  logic             r1_von;
  logic             r2_hit;
  logic [2:0]       r2_bit;
  logic             r2_von;
  logic [7:0]       r_rgb;

  logic [31:0]      w_gcol;
  logic [31:0]      w_ydiff;
  logic [31:0]      w_fsel;
  logic             w_x_in;
  logic             w_hit;
  logic [3:0]       w_row;
  logic [3:0]       w_digit;
  logic             w_blank;
  logic [6:0]       w_code;

  assign w_gcol = (32'(pixel_x_i) - 32'(X0)) >> SCALE_LOG2;
  assign w_x_in = (32'(pixel_x_i) >= 32'(X0)) && (32'(pixel_x_i) < 32'(X0 + FIELD_W));

  // Scan from the highest field down so the lowest overlapping index wins.
  always_comb begin
    w_hit   = 1'b0;
    w_fsel  = 32'd0;
    w_ydiff = 32'd0;
    for (int f = N_FIELDS - 1; f >= 0; f--) begin
      if (w_x_in && (32'(pixel_y_i) >= 32'(Y0 + f * Y_PITCH)) &&
          (32'(pixel_y_i) < 32'(Y0 + f * Y_PITCH + GLYPH_H))) begin
        w_hit   = 1'b1;
        w_fsel  = 32'(f);
        w_ydiff = 32'(pixel_y_i) - 32'(Y0 + f * Y_PITCH);
      end
    end
    w_row = 4'(w_ydiff >> SCALE_LOG2);
  end

  always_comb begin
    w_digit = 4'd0;
    for (int f = 0; f < N_FIELDS; f++) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (w_fsel == 32'(f) && w_gcol[31:3] == 29'(d)) begin
          w_digit = r_bcd[(f * DIGITS + d) * 4 +: 4];
        end
      end
    end
    w_blank = r_edit && r_blink &&
              (32'(r_cur_f) < 32'(N_FIELDS)) && (32'(r_cur_d) < 32'(DIGITS)) &&
              (32'(r_cur_f) == w_fsel) && (32'(r_cur_d) == 32'(w_gcol[31:3]));
    w_code  = (w_blank || w_digit > 4'd9) ? 7'h00 : {3'b011, w_digit};
  end

  // Shadows and blink state change only at a qualified frame start.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_bcd       <= '0;
      r_edit      <= 1'b0;
      r_cur_f     <= 4'd0;
      r_cur_d     <= 4'd0;
      r_irq       <= 1'b0;
      r_frame_cnt <= 8'd0;
      r_blink     <= 1'b0;
    end else if (pix_en_i && frame_start_i) begin
      r_bcd   <= field_bcd_i;
      r_edit  <= edit_i;
      r_cur_f <= cursor_field_i;
      r_cur_d <= cursor_digit_i;
      r_irq   <= irq_i;
      if (r_frame_cnt == 8'(BLINK_FRAMES - 1)) begin
        r_frame_cnt <= 8'd0;
        r_blink     <= ~r_blink;
      end else begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r1_hit  <= 1'b0;
      r1_code <= 7'h00;
      r1_row  <= 4'd0;
      r1_bit  <= 3'd0;
      r1_von  <= 1'b0;
      r2_hit  <= 1'b0;
      r2_bit  <= 3'd0;
      r2_von  <= 1'b0;
      r_rgb   <= 8'h00;
    end else if (pix_en_i) begin
      r1_hit  <= w_hit;
      r1_code <= w_code;
      r1_row  <= w_row;
      r1_bit  <= w_gcol[2:0];
      r1_von  <= video_on_i;
      r2_hit  <= r1_hit;
      r2_bit  <= r1_bit;
      r2_von  <= r1_von;
      if (!r2_von) begin
        r_rgb <= 8'h00;
      end else if (r2_hit && rom_data_i[3'd7 - r2_bit]) begin
        r_rgb <= FG_COLOR;
      end else if (r_irq && !r_blink) begin
        r_rgb <= ALARM_COLOR;
      end else begin
        r_rgb <= 8'h00;
      end
    end
  end

  // The ROM registers this address on the S2 edge, so its data lines up with S3.
  assign rom_addr_o = r1_hit ? {r1_code, r1_row} : 11'h000;
  assign rgb_o      = r_rgb;

endmodule

// File: tb/tb_bcd_overlay_render.sv
// tb/tb_bcd_overlay_render.sv - directed self-checking bench for bcd_overlay_render
module tb_bcd_overlay_render;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pix_en = 1'b0;
  logic [9:0]  px = '0;
  logic [9:0]  py = '0;
  logic        von = 1'b0;
  logic        fs = 1'b0;
  logic [71:0] bcd = '0;
  logic        edit = 1'b0;
  logic [3:0]  cf = '0;
  logic [3:0]  cd = '0;
  logic        irq = 1'b0;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data = 8'h00;
  logic [7:0]  rgb;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [10:0] obs_addr;
  logic [7:0]  obs_rgb;

  bcd_overlay_render #(.BLINK_FRAMES(2)) dut (
    .clk_i(clk), .reset_i(reset_n), .pix_en_i(pix_en),
    .pixel_x_i(px), .pixel_y_i(py), .video_on_i(von), .frame_start_i(fs),
    .field_bcd_i(bcd), .edit_i(edit), .cursor_field_i(cf), .cursor_digit_i(cd),
    .irq_i(irq), .rom_addr_o(rom_addr), .rom_data_i(rom_data), .rgb_o(rgb)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_f(input logic [10:0] a);
    return 8'h5A ^ a[7:0] ^ {a[3:0], a[10:7]};
  endfunction

  function automatic logic [7:0] exp_pix(input logic [10:0] a, input int b, input logic [7:0] bg);
    logic [7:0] r;
    r = rom_f(a);
    return r[7-b] ? 8'h07 : bg;
  endfunction

  always @(posedge clk) rom_data <= rom_f(rom_addr);

  task automatic run_px(input logic [9:0] x, input logic [9:0] y, input logic v);
    @(negedge clk);
    px = x; py = y; von = v; pix_en = 1'b1;
    @(posedge clk); #1;
    obs_addr = rom_addr;
    px = '0; py = '0; von = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    obs_rgb = rgb;
  endtask

  task automatic frame();
    @(negedge clk);
    fs = 1'b1; pix_en = 1'b1;
    @(posedge clk); #1;
    fs = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; pix_en = 1'b0; fs = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic set_digit(input int f, input int d, input logic [3:0] v);
    bcd[(f*6+d)*4 +: 4] = v;
  endtask

  task automatic test_reset();
    #3;
    n_tests++; if (rgb !== 8'h00) begin n_fail++; $display("FAIL reset_rgb got %h exp 00", rgb); end
    n_tests++; if (rom_addr !== 11'h000) begin n_fail++; $display("FAIL reset_addr got %h exp 000", rom_addr); end
    do_reset();
    bcd[23:0] = 24'h654321;
    run_px(10'd192, 10'd96, 1'b1);
    n_tests++; if (obs_addr !== 11'h300) begin n_fail++; $display("FAIL post_reset_addr got %h exp 300", obs_addr); end
    n_tests++; if (obs_rgb !== exp_pix(11'h300, 0, 8'h00)) begin n_fail++; $display("FAIL post_reset_rgb got %h exp %h", obs_rgb, exp_pix(11'h300, 0, 8'h00)); end
  endtask

  task automatic test_render();
    logic [9:0]  tx [7] = '{10'd192, 10'd211, 10'd286, 10'd288, 10'd191, 10'd192, 10'd200};
    logic [9:0]  ty [7] = '{10'd96, 10'd105, 10'd127, 10'd100, 10'd100, 10'd128, 10'd100};
    logic        tv [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [10:0] ta [7] = '{11'h310, 11'h324, 11'h36F, 11'h000, 11'h000, 11'h000, 11'h312};
    int          tb [7] = '{0, 1, 7, -1, -1, -1, -1};
    logic [7:0]  er;
    frame();
    for (int i = 0; i < 7; i++) begin
      run_px(tx[i], ty[i], tv[i]);
      er = (tb[i] < 0) ? 8'h00 : exp_pix(ta[i], tb[i], 8'h00);
      n_tests++; if (obs_addr !== ta[i]) begin n_fail++; $display("FAIL render_addr[%0d] got %h exp %h", i, obs_addr, ta[i]); end
      n_tests++; if (obs_rgb !== er) begin n_fail++; $display("FAIL render_rgb[%0d] got %h exp %h", i, obs_rgb, er); end
    end
  endtask

  task automatic test_pix_en_hold();
    @(negedge clk);
    px = 10'd240; py = 10'd100; von = 1'b1; pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0; px = 10'd192; py = 10'd96;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (rom_addr !== 11'h342) begin n_fail++; $display("FAIL hold_addr got %h exp 342", rom_addr); end
    n_tests++; if (rgb !== 8'h00) begin n_fail++; $display("FAIL hold_rgb got %h exp 00", rgb); end
    px = '0; py = '0; von = 1'b0; pix_en = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    n_tests++; if (rgb !== exp_pix(11'h342, 0, 8'h00)) begin n_fail++; $display("FAIL hold_resume_rgb got %h exp %h", rgb, exp_pix(11'h342, 0, 8'h00)); end
  endtask

  task automatic test_tearing();
    bcd[23:0] = 24'h456789;
    run_px(10'd192, 10'd96, 1'b1);
    n_tests++; if (obs_addr !== 11'h310) begin n_fail++; $display("FAIL tear_same_frame got %h exp 310", obs_addr); end
    frame();
    run_px(10'd192, 10'd96, 1'b1);
    n_tests++; if (obs_addr !== 11'h390) begin n_fail++; $display("FAIL tear_next_frame got %h exp 390", obs_addr); end
  endtask

  task automatic test_blink();
    logic [10:0] ea;
    do_reset();
    edit = 1'b1; cf = 4'd1; cd = 4'd3;
    set_digit(1, 3, 4'd7);
    set_digit(1, 2, 4'd2);
    for (int k = 1; k <= 6; k++) begin
      frame();
      run_px(10'd240, 10'd266, 1'b1);
      ea = (k == 2 || k == 3 || k == 6) ? 11'h005 : 11'h375;
      n_tests++; if (obs_addr !== ea) begin n_fail++; $display("FAIL blink_fs%0d got %h exp %h", k, obs_addr, ea); end
      if (k == 2 || k == 3 || k == 6) begin
        run_px(10'd224, 10'd266, 1'b1);
        n_tests++; if (obs_addr !== 11'h325) begin n_fail++; $display("FAIL blink_neighbour_fs%0d got %h exp 325", k, obs_addr); end
      end
    end
    edit = 1'b0;
  endtask

  task automatic test_irq();
    do_reset();
    irq = 1'b1;
    frame();
    run_px(10'd100, 10'd50, 1'b1);
    n_tests++; if (obs_rgb !== 8'h1A) begin n_fail++; $display("FAIL irq_bg_phase0 got %h exp 1a", obs_rgb); end
    run_px(10'd100, 10'd50, 1'b0);
    n_tests++; if (obs_rgb !== 8'h00) begin n_fail++; $display("FAIL irq_blanking got %h exp 00", obs_rgb); end
    run_px(10'd192, 10'd96, 1'b1);
    n_tests++; if (obs_rgb !== exp_pix(11'h390, 0, 8'h1A)) begin n_fail++; $display("FAIL irq_glyph_b0 got %h exp %h", obs_rgb, exp_pix(11'h390, 0, 8'h1A)); end
    run_px(10'd196, 10'd96, 1'b1);
    n_tests++; if (obs_rgb !== exp_pix(11'h390, 2, 8'h1A)) begin n_fail++; $display("FAIL irq_glyph_b2 got %h exp %h", obs_rgb, exp_pix(11'h390, 2, 8'h1A)); end
    frame();
    run_px(10'd100, 10'd50, 1'b1);
    n_tests++; if (obs_rgb !== 8'h00) begin n_fail++; $display("FAIL irq_bg_phase1 got %h exp 00", obs_rgb); end
    run_px(10'd192, 10'd96, 1'b1);
    n_tests++; if (obs_rgb !== exp_pix(11'h390, 0, 8'h00)) begin n_fail++; $display("FAIL irq_glyph_phase1 got %h exp %h", obs_rgb, exp_pix(11'h390, 0, 8'h00)); end
    irq = 1'b0;
  endtask

  task automatic test_bad_digit();
    do_reset();
    edit = 1'b1; cf = 4'd5; cd = 4'd9;
    set_digit(2, 0, 4'hC);
    set_digit(2, 1, 4'd4);
    frame();
    frame();
    run_px(10'd192, 10'd422, 1'b1);
    n_tests++; if (obs_addr !== 11'h003) begin n_fail++; $display("FAIL bad_digit_addr got %h exp 003", obs_addr); end
    n_tests++; if (obs_rgb !== exp_pix(11'h003, 0, 8'h00)) begin n_fail++; $display("FAIL bad_digit_rgb got %h exp %h", obs_rgb, exp_pix(11'h003, 0, 8'h00)); end
    run_px(10'd208, 10'd422, 1'b1);
    n_tests++; if (obs_addr !== 11'h343) begin n_fail++; $display("FAIL oob_cursor_addr got %h exp 343", obs_addr); end
    run_px(10'd192, 10'd656, 1'b1);
    n_tests++; if (obs_addr !== 11'h000) begin n_fail++; $display("FAIL below_fields_addr got %h exp 000", obs_addr); end
    edit = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    irq = 1'b1;
    frame();
    @(negedge clk);
    px = 10'd192; py = 10'd96; von = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pix_en = ~pix_en;
      @(negedge clk);
    end
    pix_en = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    n_tests++; if (rgb !== 8'h00) begin n_fail++; $display("FAIL async_rgb got %h exp 00", rgb); end
    n_tests++; if (rom_addr !== 11'h000) begin n_fail++; $display("FAIL async_addr got %h exp 000", rom_addr); end
    @(negedge clk); pix_en = 1'b0;
    @(negedge clk); pix_en = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    run_px(10'd100, 10'd50, 1'b1);
    n_tests++; if (obs_rgb !== 8'h00) begin n_fail++; $display("FAIL async_irq_cleared got %h exp 00", obs_rgb); end
    frame();
    run_px(10'd100, 10'd50, 1'b1);
    n_tests++; if (obs_rgb !== 8'h1A) begin n_fail++; $display("FAIL async_cnt_fs1 got %h exp 1a", obs_rgb); end
    frame();
    run_px(10'd100, 10'd50, 1'b1);
    n_tests++; if (obs_rgb !== 8'h00) begin n_fail++; $display("FAIL async_cnt_fs2 got %h exp 00", obs_rgb); end
    irq = 1'b0;
  endtask

  initial begin
    test_reset();
    test_render();
    test_pix_en_hold();
    test_tearing();
    test_blink();
    test_irq();
    test_bad_digit();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
